ws2812_frame_sequencer: RTL
===========================

Name: ws2812_frame_sequencer

Overview:
- Upstream neighbour of the WS2812 unipolar RZ encoder.
- Accepts 24-bit pixel words with an end-of-frame flag over a valid/ready stream.
- Answers the encoder's cmd_request/data_request pulses with a command (IDLE/TX/RESET) and the next serial data bit, MSB first.
- After the last bit of a frame it issues one RESET (latch) command. A one-entry prefetch buffer keeps consecutive pixels gap-free.

Parameters:
BITS_PER_PIXEL, 24, pixel word width; bits sent MSB first.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
pixel_data  input  BITS_PER_PIXEL  pixel word (GRB order, packed by producer).
pixel_last  input  1  pixel is the final one of a frame.
pixel_valid  input  1  producer has a word.
pixel_ready  output  1  sequencer accepts a word this cycle.
cmd_request  input  1  encoder command fetch pulse (1 cycle).
data_request  input  1  encoder data prefetch pulse (1 cycle).
command  output  2  00 IDLE, 01 TX, 10 RESET; 11 never driven.
databit  output  1  bit to be sampled by encoder.
busy  output  1  a frame is in progress.
underrun  output  1  1-cycle pulse: pixel ended mid-frame with no word buffered.
frame_done  output  1  1-cycle pulse: RESET command consumed by encoder.

Behaviour:
- Encoder contract:
  - A request (cmd_request or data_request) high in cycle N samples command in cycle N.
  - If that command is TX, databit is sampled in cycle N+1.
  - Requests are at least 2 cycles apart.
- Output timing:
  - command and databit are registered and hold stable through cycles N and N+1.
  - Advancing happens at the end of cycle N+1 (a pending flag set in N, applied in N+1).
  - A request arriving while the pending flag is set is ignored; the bench flags it as a protocol violation.
- Storage:
  - Prefetch buffer: buf_data, buf_last, buf_valid.
  - pixel_ready = ~buf_valid & ~rst.
  - Push occurs on pixel_valid & pixel_ready.
  - Push and pop never coincide.
- Shifter: shift register sh plus sh_last and bit_cnt (width $clog2(BITS_PER_PIXEL)). databit = sh MSB while in SEND, otherwise 0.
- States:
  - EMPTY: command=IDLE. If buf_valid, load sh from the buffer, set bit_cnt=0, pop the buffer, go to SEND (command=TX visible the next cycle).
  - SEND: command=TX. On advance:
    - If bit_cnt < BITS_PER_PIXEL-1: shift left by 1 and increment bit_cnt.
    - Otherwise, at the pixel end:
      - If buf_valid: load the buffer, pop it, set bit_cnt=0, stay in SEND.
      - Else if sh_last: go to LATCH.
      - Else: go to EMPTY and pulse underrun.
  - LATCH: command=RESET. On advance (the request that sampled RESET), go to EMPTY and pulse frame_done. databit is not consumed.
- Requests while command=IDLE consume nothing; no state change.
- busy = 1 from the first load out of EMPTY until the frame_done cycle. It stays 1 across an underrun until the frame completes.
- Reset (synchronous, any state, including mid-bit or mid-latch):
  - state=EMPTY, buf_valid=0, bit_cnt=0, sh=0, pending=0.
  - command=00, databit=0, busy=0, underrun=0, frame_done=0.
  - pixel_ready=0 while rst is high and 1 on the first cycle after.
- Latency: pixel accepted in cycle A → command=TX at cycle A+2 (buffer empty, state EMPTY).

Test Plan:
- Single pixel 0xA5F00F, last=1, with a behavioural encoder model (cmd/data pulses every 12 cycles) → databit sequence 1010_0101_1111_0000_0000_1111, then exactly one RESET sampled, frame_done pulses once, busy falls the same cycle, command returns to 00.
- Three back-to-back pixels (0xFFFFFF, 0x000000, 0x800001 last) with the producer always valid → 72 TX samples with no IDLE sampled between pixels, pixel_ready toggles as the buffer drains, then one RESET.
- Two pixels, second arrives 200 cycles late, first last=0 → underrun pulses once after bit 24, IDLE is sampled while waiting, the second pixel then transmits and the frame completes with frame_done.
- Hold check: request in cycle N with TX → command and databit unchanged at N+1, and databit changes only at the end of N+1.
- rst asserted mid-pixel (bit 10) and again while in LATCH → next cycle command=00, databit=0, busy=0, pixel_ready=1 one cycle after rst drops, and the next frame starts from bit 23.
- Idle encoder loop (cmd_request every 2 cycles, no pixels) for 100 cycles → command stays 00, no pulses, no state change.

Source files
------------

// File: rtl/ws2812_frame_sequencer.sv
`timescale 1ns/1ps
// Pixel-stream to bit-stream sequencer that feeds the WS2812 RZ encoder.
// It sends bits MSB first, uses a one-word prefetch buffer, and ends each frame with one RESET (latch) command.
module ws2812_frame_sequencer #(
  parameter int BITS_PER_PIXEL = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  input  logic                      pixel_last,
  input  logic                      pixel_valid,
  output logic                      pixel_ready,
  input  logic                      cmd_request,
  input  logic                      data_request,
  output logic [1:0]                command,
  output logic                      databit,
  output logic                      busy,
  output logic                      underrun,
  output logic                      frame_done
);

  localparam int CNT_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_PIXEL - 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_TX    = 2'b01;
  localparam logic [1:0] CMD_RESET = 2'b10;

  logic [1:0]                state, state_n;
  logic [BITS_PER_PIXEL-1:0] buf_data;
  logic                      buf_last;
  logic                      buf_valid;
  logic [BITS_PER_PIXEL-1:0] sh, sh_n;
  logic                      sh_last, sh_last_n;
  logic [CNT_W-1:0]          bit_cnt, bit_cnt_n;
  logic                      pending;
  logic                      accept_req;
  logic                      push, pop;
  logic                      busy_n, underrun_n, frame_done_n;

  assign pixel_ready = ~buf_valid & ~rst;
  assign push        = pixel_valid & pixel_ready;

  // A request only counts when the encoder is sampling TX or RESET.
  // Requests that arrive while an advance is still pending are dropped.
  assign accept_req = (cmd_request | data_request) & ~pending & (state != ST_EMPTY);

  always_comb begin
    state_n      = state;
    sh_n         = sh;
    sh_last_n    = sh_last;
    bit_cnt_n    = bit_cnt;
    pop          = 1'b0;
    busy_n       = busy;
    underrun_n   = 1'b0;
    frame_done_n = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (buf_valid) begin
          sh_n      = buf_data;
          sh_last_n = buf_last;
          bit_cnt_n = '0;
          pop       = 1'b1;
          busy_n    = 1'b1;
          state_n   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pending) begin
          if (bit_cnt < LAST_BIT) begin
            sh_n      = sh << 1;
            bit_cnt_n = bit_cnt + 1'b1;
          end else if (buf_valid) begin
            sh_n      = buf_data;
            sh_last_n = buf_last;
            bit_cnt_n = '0;
            pop       = 1'b1;
          end else if (sh_last) begin
            state_n = ST_LATCH;
          end else begin
            state_n    = ST_EMPTY;
            underrun_n = 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (pending) begin
          state_n      = ST_EMPTY;
          busy_n       = 1'b0;
          frame_done_n = 1'b1;
        end
      end
      default: state_n = ST_EMPTY;
    endcase
  end

  // The outputs are computed from the next state, so they are registered and change only when the sequencer advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_EMPTY;
      sh         <= '0;
      sh_last    <= 1'b0;
      bit_cnt    <= '0;
      pending    <= 1'b0;
      command    <= CMD_IDLE;
      databit    <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      sh         <= sh_n;
      sh_last    <= sh_last_n;
      bit_cnt    <= bit_cnt_n;
      pending    <= accept_req;
      busy       <= busy_n;
      underrun   <= underrun_n;
      frame_done <= frame_done_n;
      case (state_n)
        ST_SEND:  command <= CMD_TX;
        ST_LATCH: command <= CMD_RESET;
        default:  command <= CMD_IDLE;
      endcase
      databit <= (state_n == ST_SEND) ? sh_n[BITS_PER_PIXEL-1] : 1'b0;
    end
  end

  // A push and a pop never happen in the same cycle, because the buffer must be empty to accept a word.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
      buf_last  <= 1'b0;
    end else if (push) begin
      buf_valid <= 1'b1;
      buf_data  <= pixel_data;
      buf_last  <= pixel_last;
    end else if (pop) begin
      buf_valid <= 1'b0;
    end
  end

endmodule
